// File: rtl/idu_stage_if.sv
// idu_stage_if: decode stage bus; upstream in_valid/in_ready/in_inst/in_pc, downstream out_valid/out_ready and registered decoded fields
interface idu_stage_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_imm;
  logic [3:0]      out_alu_op;
  logic            out_src2_imm;
  logic            out_reg_wr;
  logic            out_word;
  logic            out_mem_rd;
  logic            out_mem_wr;
  logic            out_branch;
  logic            out_jump;
  logic            out_ebreak;
  logic            out_illegal;
  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
           out_src2_imm, out_reg_wr, out_word, out_mem_rd, out_mem_wr, out_branch,
           out_jump, out_ebreak, out_illegal
  );
  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
           out_src2_imm, out_reg_wr, out_word, out_mem_rd, out_mem_wr, out_branch,
           out_jump, out_ebreak, out_illegal
  );
endinterface

// File: rtl/idu_stage.sv
// idu_stage: single-entry RV32I/RV64I decode register; ports clk, rst (async high), flush_i, bus (slave: in_* handshake in, decoded out_* entry out)
module idu_stage #(
  parameter int XLEN = 64
) (
  input logic        clk,
  input logic        rst,
  input logic        flush_i,
  idu_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            src2_imm, reg_wr, word, mem_rd, mem_wr, branch, jump, ebreak, illegal;
  } ent_t;
  localparam bit RV64 = XLEN == 64;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8,
    ALU_AND = 4'd9, ALU_PASS = 4'd10;
  ent_t base, dec, ent_d, ent_q;
  logic valid_d, valid_q, cap, legal, wr, sh_rsv;
  logic [31:0] inst, imm32, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [3:0] alu_f;
  assign inst  = bus.in_inst;
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  assign sh_rsv = inst[31] | (|inst[29:26]) | (!RV64 & inst[25]);
  always_comb begin
    case (f3)
      3'd0:    alu_f = ALU_ADD;
      3'd1:    alu_f = ALU_SLL;
      3'd2:    alu_f = ALU_SLT;
      3'd3:    alu_f = ALU_SLTU;
      3'd4:    alu_f = ALU_XOR;
      3'd5:    alu_f = inst[30] ? ALU_SRA : ALU_SRL;
      3'd6:    alu_f = ALU_OR;
      default: alu_f = ALU_AND;
    endcase
  end
  always_comb begin
    base = '0;
    base.pc  = bus.in_pc;
    base.rs1 = inst[19:15];
    base.rs2 = inst[24:20];
    base.rd  = inst[11:7];
    dec   = base;
    imm32 = '0;
    wr    = 1'b0;
    legal = 1'b1;
    case (inst[6:0])
      7'b0110111: begin imm32 = imm_u; dec.alu_op = ALU_PASS; dec.src2_imm = 1'b1; wr = 1'b1; end
      7'b0010111: begin imm32 = imm_u; dec.src2_imm = 1'b1; wr = 1'b1; end
      7'b1101111: begin imm32 = imm_j; dec.jump = 1'b1; dec.src2_imm = 1'b1; wr = 1'b1; end
      7'b1100111: begin imm32 = imm_i; dec.jump = 1'b1; dec.src2_imm = 1'b1; wr = 1'b1; end
      7'b1100011: begin imm32 = imm_b; dec.branch = 1'b1; legal = f3[2:1] != 2'b01; end
      7'b0000011: begin
        imm32 = imm_i; dec.mem_rd = 1'b1; dec.src2_imm = 1'b1; wr = 1'b1;
        legal = f3 != 3'd7 && (RV64 || (f3 != 3'd3 && f3 != 3'd6));
      end
      7'b0100011: begin
        imm32 = imm_s; dec.mem_wr = 1'b1; dec.src2_imm = 1'b1;
        legal = !f3[2] && (RV64 || f3 != 3'd3);
      end
      7'b0010011: begin
        imm32 = imm_i; dec.alu_op = alu_f; dec.src2_imm = 1'b1; wr = 1'b1;
        legal = f3 == 3'd1 ? !(sh_rsv | inst[30]) : f3 == 3'd5 ? !sh_rsv : 1'b1;
      end
      7'b0110011: begin
        dec.alu_op = (f3 == 3'd0 && inst[30]) ? ALU_SUB : alu_f; wr = 1'b1;
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b0011011: begin
        imm32 = imm_i; dec.alu_op = alu_f; dec.src2_imm = 1'b1; dec.word = 1'b1; wr = 1'b1;
        legal = RV64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) ||
                (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
      end
      7'b0111011: begin
        dec.alu_op = (f3 == 3'd0 && inst[30]) ? ALU_SUB : alu_f; dec.word = 1'b1; wr = 1'b1;
        legal = RV64 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b1110011: begin imm32 = imm_i; dec.ebreak = 1'b1; dec.src2_imm = 1'b1; legal = inst == 32'h0010_0073; end
      default:    legal = 1'b0;
    endcase
    dec.imm    = XLEN'($signed(imm32));
    dec.reg_wr = wr && dec.rd != 5'd0;
    if (!legal) dec = base;
    dec.illegal = !legal;
  end
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign cap     = bus.in_valid && bus.in_ready && !flush_i;
  assign valid_d = cap || (valid_q && !bus.out_ready && !flush_i);
  assign ent_d   = cap ? dec : ent_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
    end
  end
  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = ent_q.pc;
  assign bus.out_imm      = ent_q.imm;
  assign bus.out_rs1      = ent_q.rs1;
  assign bus.out_rs2      = ent_q.rs2;
  assign bus.out_rd       = ent_q.rd;
  assign bus.out_alu_op   = ent_q.alu_op;
  assign bus.out_src2_imm = ent_q.src2_imm;
  assign bus.out_reg_wr   = ent_q.reg_wr;
  assign bus.out_word     = ent_q.word;
  assign bus.out_mem_rd   = ent_q.mem_rd;
  assign bus.out_mem_wr   = ent_q.mem_wr;
  assign bus.out_branch   = ent_q.branch;
  assign bus.out_jump     = ent_q.jump;
  assign bus.out_ebreak   = ent_q.ebreak;
  assign bus.out_illegal  = ent_q.illegal;
endmodule

// File: tb/tb_idu_stage.sv
// tb_idu_stage: directed and randomized checks of idu_stage at XLEN 64 and 32 against a decode reference model
module tb_idu_stage;
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        s2i, wr, word, mrd, mwr, br, jmp, eb, ill;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, fl = 1'b0, iv = 1'b0, ordy = 1'b0;
  logic [31:0] ins = '0;
  logic [63:0] pcv = '0;
  logic ev = 1'b0;
  exp_t e64 = '0, e32 = '0;
  int total = 0, bad = 0;
  idu_stage_if #(.XLEN(64)) b64 ();
  idu_stage_if #(.XLEN(32)) b32 ();
  idu_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush_i(fl), .bus(b64));
  idu_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush_i(fl), .bus(b32));
  assign b64.in_valid  = iv;
  assign b32.in_valid  = iv;
  assign b64.in_inst   = ins;
  assign b32.in_inst   = ins;
  assign b64.in_pc     = pcv;
  assign b32.in_pc     = pcv[31:0];
  assign b64.out_ready = ordy;
  assign b32.out_ready = ordy;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t got64();
    return {b64.out_pc, b64.out_imm, b64.out_rs1, b64.out_rs2, b64.out_rd, b64.out_alu_op,
            b64.out_src2_imm, b64.out_reg_wr, b64.out_word, b64.out_mem_rd, b64.out_mem_wr,
            b64.out_branch, b64.out_jump, b64.out_ebreak, b64.out_illegal};
  endfunction
  function automatic exp_t got32();
    return {32'b0, b32.out_pc, 32'b0, b32.out_imm, b32.out_rs1, b32.out_rs2, b32.out_rd, b32.out_alu_op,
            b32.out_src2_imm, b32.out_reg_wr, b32.out_word, b32.out_mem_rd, b32.out_mem_wr,
            b32.out_branch, b32.out_jump, b32.out_ebreak, b32.out_illegal};
  endfunction
  function automatic exp_t ref_dec(logic [31:0] i, logic [63:0] pc, bit rv64);
    exp_t e;
    longint s, imm;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok, wr, si, sft;
    int a;
    int base [8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    s = longint'($signed(i));
    f3 = i[14:12];
    f7 = i[31:25];
    sft = f3 == 3'd5 && i[30];
    e = '0;
    ok = 1'b0; wr = 1'b0; si = 1'b1; a = 0;
    imm = s >>> 20;
    case (i[6:0])
      7'h37: begin ok = 1; wr = 1; a = 10; imm = (s >>> 12) << 12; end
      7'h17: begin ok = 1; wr = 1; imm = (s >>> 12) << 12; end
      7'h6f: begin
        ok = 1; wr = 1; e.jmp = 1;
        imm = ((s >>> 31) << 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      end
      7'h67: begin ok = 1; wr = 1; e.jmp = 1; end
      7'h63: begin
        ok = f3 != 3'd2 && f3 != 3'd3; e.br = 1; si = 0;
        imm = ((s >>> 31) << 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      end
      7'h03: begin ok = f3 != 3'd7 && (rv64 || (f3 != 3'd3 && f3 != 3'd6)); e.mrd = 1; wr = 1; end
      7'h23: begin ok = f3 < 3'd3 || (f3 == 3'd3 && rv64); e.mwr = 1; imm = ((s >>> 25) << 5) | longint'(i[11:7]); end
      7'h13: begin
        wr = 1; a = base[f3] + int'(sft);
        if (f3 == 3'd1) ok = rv64 ? i[31:26] == 6'h00 : f7 == 7'h00;
        else if (f3 == 3'd5) ok = rv64 ? (i[31:26] == 6'h00 || i[31:26] == 6'h10) : (f7 == 7'h00 || f7 == 7'h20);
        else ok = 1;
      end
      7'h33: begin
        wr = 1; si = 0; imm = 0; a = base[f3] + int'(f7 == 7'h20);
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h1b: begin
        wr = 1; e.word = 1; a = base[f3] + int'(sft);
        ok = rv64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) || (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
      end
      7'h3b: begin
        wr = 1; si = 0; imm = 0; e.word = 1; a = base[f3] + int'(f7 == 7'h20);
        ok = rv64 && (f7 == 7'h00 ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5) : (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h73: begin ok = i == 32'h0010_0073; e.eb = 1; end
      default: ok = 0;
    endcase
    e.pc  = rv64 ? pc : {32'b0, pc[31:0]};
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd  = i[11:7];
    if (ok) begin
      e.imm = rv64 ? imm : {32'b0, imm[31:0]};
      e.alu = 4'(a);
      e.s2i = si;
      e.wr  = wr && i[11:7] != 5'd0;
    end else begin
      {e.word, e.mrd, e.mwr, e.br, e.jmp, e.eb} = '0;
      e.ill = 1;
    end
    return e;
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1b, 7'h3b, 7'h73};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 1) == 1) r[31:25] = $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00;
    if ($urandom_range(0, 9) == 0) r = $urandom;
    else if ($urandom_range(0, 9) == 0) r = 32'h0010_0073;
    return r;
  endfunction
  task automatic tick();
    logic cap, nv;
    exp_t n64, n32;
    #1;
    chk("in_ready64", b64.in_ready, !ev || ordy);
    chk("in_ready32", b32.in_ready, !ev || ordy);
    cap = iv && (!ev || ordy) && !fl;
    n64 = ref_dec(ins, pcv, 1'b1);
    n32 = ref_dec(ins, pcv, 1'b0);
    nv = cap || (ev && !ordy && !fl);
    @(posedge clk);
    #1;
    ev = nv;
    if (cap) begin
      e64 = n64;
      e32 = n32;
    end
    chk("valid64", b64.out_valid, ev);
    chk("valid32", b32.out_valid, ev);
    if (ev) begin
      chk("entry64", got64(), e64);
      chk("entry32", got32(), e32);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid64", b64.out_valid, 0);
    chk("rst_entry64", got64(), 0);
    chk("rst_entry32", got32(), 0);
    chk("rst_ready64", b64.in_ready, 1);
    rst = 1'b0;
    iv = 1; ordy = 1; ins = 32'h0050_0093; pcv = 64'h8000_1000;
    tick();
    chk("addi_valid", b64.out_valid, 1);
    chk("addi_rd", b64.out_rd, 1);
    chk("addi_rs1", b64.out_rs1, 0);
    chk("addi_imm", b64.out_imm, 5);
    chk("addi_alu", b64.out_alu_op, 0);
    chk("addi_src2imm", b64.out_src2_imm, 1);
    chk("addi_regwr", b64.out_reg_wr, 1);
    ins = 32'hFFF0_0093;
    tick();
    chk("imm_neg64", b64.out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("imm_neg32", b32.out_imm, 32'hFFFF_FFFF);
    iv = 0;
    tick();
    iv = 1; ordy = 0; ins = 32'h0050_0093; pcv = 64'h100;
    tick();
    ins = 32'h00A0_0113; pcv = 64'h104;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ready", b64.in_ready, 0);
      chk("bp_hold_rd", b64.out_rd, 1);
      chk("bp_hold_imm", b64.out_imm, 5);
    end
    ordy = 1;
    tick();
    chk("bp_second_rd", b64.out_rd, 2);
    chk("bp_second_imm", b64.out_imm, 10);
    iv = 0;
    tick();
    chk("bp_drained", b64.out_valid, 0);
    iv = 1; ins = 32'h0000_0000;
    tick();
    chk("zero_illegal", b64.out_illegal, 1);
    chk("zero_regwr", b64.out_reg_wr, 0);
    ins = 32'h0010_0073;
    tick();
    chk("ebreak64", b64.out_ebreak, 1);
    chk("ebreak32", b32.out_ebreak, 1);
    ins = 32'h0010_009B;
    tick();
    chk("addiw_ill32", b32.out_illegal, 1);
    chk("addiw_ok64", b64.out_illegal, 0);
    chk("addiw_word64", b64.out_word, 1);
    ins = 32'h0050_0093; fl = 1;
    tick();
    chk("flush_cap", b64.out_valid, 0);
    fl = 0; ordy = 0;
    tick();
    iv = 0; fl = 1;
    tick();
    chk("flush_held", b64.out_valid, 0);
    fl = 0; iv = 1;
    tick();
    chk("pre_arst", b64.out_valid, 1);
    iv = 0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid64", b64.out_valid, 0);
    chk("arst_valid32", b32.out_valid, 0);
    chk("arst_entry64", got64(), 0);
    chk("arst_ready", b64.in_ready, 1);
    ev = 0; e64 = '0; e32 = '0;
    #1 rst = 1'b0;
    ordy = 1;
    repeat (2) tick();
    for (int k = 0; k < 600; k++) begin
      iv = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 3) != 0;
      fl = $urandom_range(0, 15) == 0;
      ins = rand_inst();
      pcv = {$urandom, $urandom};
      tick();
    end
    fl = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
